// File: rtl/uart_rx_cts_if.sv
// uart_rx_cts_if: serial line, flow control and received-byte handshake
interface uart_rx_cts_if;
  logic       uart_rx;
  logic       uart_cts;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       framing_err;
  logic       overrun_err;
  modport master (output uart_rx, rx_ready, input uart_cts, rx_data, rx_valid, framing_err, overrun_err);
  modport slave (input uart_rx, rx_ready, output uart_cts, rx_data, rx_valid, framing_err, overrun_err);
endinterface

// File: rtl/uart_rx_cts.sv
// uart_rx_cts: 8N1 UART receiver with byte FIFO and CTS flow control with hysteresis
module uart_rx_cts #(
  parameter int CLK_FREQ   = 25000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input logic          clk25,
  input logic          rst_n,
  uart_rx_cts_if.slave bus
);
  localparam int BIT_TICKS  = CLK_FREQ / BAUD;
  localparam int HALF_TICKS = BIT_TICKS / 2;
  localparam int TW         = $clog2(BIT_TICKS);
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int CW         = AW + 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state_q, state_d;
  logic          sync1_q, sync2_q;
  logic          armed_q, armed_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q, count_d;
  logic          cts_q, cts_d, ferr_q, ferr_d, oerr_q;
  logic          line, half_end, bit_end, push, pop, push_ok, valid;
  assign line     = sync2_q;
  assign half_end = tick_q == TW'(HALF_TICKS - 1);
  assign bit_end  = tick_q == TW'(BIT_TICKS - 1);
  assign valid    = count_q != '0;
  assign pop      = valid && bus.rx_ready;
  assign push_ok  = push && (count_q < CW'(FIFO_DEPTH) || pop);
  assign count_d  = count_q + CW'(push_ok) - CW'(pop);
  assign cts_d    = count_q >= CW'(FIFO_DEPTH - 2) ? 1'b1 : count_q <= CW'(FIFO_DEPTH / 2) ? 1'b0 : cts_q;
  assign bus.rx_valid    = valid;
  assign bus.rx_data     = valid ? mem_q[rd_q] : 8'h00;
  assign bus.uart_cts    = cts_q;
  assign bus.framing_err = ferr_q;
  assign bus.overrun_err = oerr_q;
  // Receiver FSM; armed_q blocks a restart until the line has been seen high after a frame
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    push    = 1'b0;
    ferr_d  = 1'b0;
    armed_d = line || (state_q == IDLE && armed_q);
    case (state_q)
      IDLE: begin
        tick_d = '0;
        if (!line && armed_q) state_d = START;
      end
      START: if (half_end) begin
        tick_d  = '0;
        bit_d   = '0;
        state_d = line ? IDLE : DATA;
      end
      DATA: if (bit_end) begin
        tick_d  = '0;
        shift_d = {line, shift_q[7:1]};
        bit_d   = bit_q + 1'b1;
        if (bit_q == 3'd7) state_d = STOP;
      end
      default: if (bit_end) begin
        tick_d  = '0;
        push    = line;
        ferr_d  = !line;
        state_d = IDLE;
      end
    endcase
  end
  // State, synchronizer, FIFO pointers, flow control and error pulse registers
  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      armed_q <= 1'b0;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      cts_q   <= 1'b1;
      ferr_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= bus.uart_rx;
      sync2_q <= sync1_q;
      armed_q <= armed_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      wr_q    <= wr_q + AW'(push_ok);
      rd_q    <= rd_q + AW'(pop);
      count_q <= count_d;
      cts_q   <= cts_d;
      ferr_q  <= ferr_d;
      oerr_q  <= push && !push_ok;
    end
  end
  // FIFO storage, written with the completed byte on an accepted push
  always_ff @(posedge clk25) begin
    if (rst_n && push_ok) mem_q[wr_q] <= shift_q;
  end
endmodule

// File: tb/tb_uart_rx_cts.sv
// tb_uart_rx_cts: directed vector and sequence checks for uart_rx_cts
module tb_uart_rx_cts;
  localparam int BIT = 217;
  logic clk25 = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int vcyc = 0;
  int ferr_n = 0;
  int oerr_n = 0;
  logic [7:0] last_data = 8'h00;
  uart_rx_cts_if bus ();
  uart_rx_cts dut (.clk25(clk25), .rst_n(rst_n), .bus(bus));
  always #5 clk25 = ~clk25;
  typedef struct {
    logic [7:0] b;
    logic       stop;
    int         stop_len;
    int         glitch;
    int         gap;
    int         exp_v;
    logic [7:0] exp_d;
    int         exp_f;
  } vec_t;
  vec_t vecs [6];
  always @(negedge clk25) begin
    if (bus.rx_valid) begin
      vcyc++;
      last_data = bus.rx_data;
    end
    if (bus.framing_err) ferr_n++;
    if (bus.overrun_err) oerr_n++;
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk25);
    #1;
  endtask
  task automatic send(input logic [7:0] b, input logic stop, input int stop_len);
    bus.uart_rx = 1'b0;
    idle(BIT);
    for (int i = 0; i < 8; i++) begin
      bus.uart_rx = b[i];
      idle(BIT);
    end
    bus.uart_rx = stop;
    idle(stop_len);
    bus.uart_rx = 1'b1;
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, " rx_valid"}, int'(bus.rx_valid), 0);
    chk({tag, " rx_data"}, int'(bus.rx_data), 0);
    chk({tag, " uart_cts"}, int'(bus.uart_cts), 1);
    chk({tag, " framing_err"}, int'(bus.framing_err), 0);
    chk({tag, " overrun_err"}, int'(bus.overrun_err), 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int v0, f0, o0;
    vecs[0] = '{8'hA5, 1'b1, BIT, 0, 100, 1, 8'hA5, 0};
    vecs[1] = '{8'h00, 1'b1, BIT, 50, 300, 0, 8'h00, 0};
    vecs[2] = '{8'h3C, 1'b0, BIT + 500, 0, 2400, 0, 8'h00, 1};
    vecs[3] = '{8'h55, 1'b1, BIT, 0, 100, 1, 8'h55, 0};
    vecs[4] = '{8'h00, 1'b1, BIT, 0, 100, 1, 8'h00, 0};
    vecs[5] = '{8'h81, 1'b1, BIT, 0, 100, 1, 8'h81, 0};
    bus.uart_rx = 1'b1;
    bus.rx_ready = 1'b0;
    idle(4);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    idle(1);
    chk("cts after reset release", int'(bus.uart_cts), 0);
    idle(20);
    bus.rx_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      v0 = vcyc;
      f0 = ferr_n;
      o0 = oerr_n;
      if (vecs[i].glitch > 0) begin
        bus.uart_rx = 1'b0;
        idle(vecs[i].glitch);
        bus.uart_rx = 1'b1;
      end else send(vecs[i].b, vecs[i].stop, vecs[i].stop_len);
      idle(vecs[i].gap);
      chk($sformatf("vec%0d valid cycles", i), vcyc - v0, vecs[i].exp_v);
      chk($sformatf("vec%0d framing pulses", i), ferr_n - f0, vecs[i].exp_f);
      chk($sformatf("vec%0d overrun pulses", i), oerr_n - o0, 0);
      if (vecs[i].exp_v != 0) chk($sformatf("vec%0d data", i), int'(last_data), int'(vecs[i].exp_d));
      chk($sformatf("vec%0d valid idle", i), int'(bus.rx_valid), 0);
    end
    bus.rx_ready = 1'b0;
    o0 = oerr_n;
    for (int k = 1; k <= 9; k++) begin
      send(8'(k), 1'b1, BIT);
      idle(5);
      chk($sformatf("fill%0d cts", k), int'(bus.uart_cts), k >= 6 ? 1 : 0);
      chk($sformatf("fill%0d head", k), int'(bus.rx_data), 1);
    end
    chk("ninth byte overrun", oerr_n - o0, 1);
    idle(50);
    chk("head stable", int'(bus.rx_data), 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d valid", i), int'(bus.rx_valid), 1);
      chk($sformatf("drain%0d data", i), int'(bus.rx_data), i + 1);
      bus.rx_ready = 1'b1;
      idle(1);
      bus.rx_ready = 1'b0;
      idle(1);
      chk($sformatf("drain%0d cts", i), int'(bus.uart_cts), (7 - i) > 4 ? 1 : 0);
    end
    chk("drained valid", int'(bus.rx_valid), 0);
    for (int k = 0; k < 8; k++) begin
      send(8'h11 + 8'(k), 1'b1, BIT);
      idle(5);
    end
    o0 = oerr_n;
    fork
      send(8'h19, 1'b1, BIT);
      begin
        idle(2063);
        bus.rx_ready = 1'b1;
        idle(1);
        bus.rx_ready = 1'b0;
      end
    join
    idle(20);
    chk("full push+pop overrun", oerr_n - o0, 0);
    chk("full push+pop cts", int'(bus.uart_cts), 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("wrap%0d data", i), int'(bus.rx_data), 8'h12 + i);
      bus.rx_ready = 1'b1;
      idle(1);
      bus.rx_ready = 1'b0;
    end
    chk("wrap drained", int'(bus.rx_valid), 0);
    send(8'h77, 1'b1, BIT);
    idle(5);
    chk("buffered before reset", int'(bus.rx_valid), 1);
    f0 = ferr_n;
    o0 = oerr_n;
    bus.uart_rx = 1'b0;
    idle(5 * BIT + 60);
    rst_n = 1'b0;
    bus.uart_rx = 1'b1;
    idle(3);
    chk_reset_outputs("midframe reset");
    rst_n = 1'b1;
    idle(1);
    chk("cts after midframe reset", int'(bus.uart_cts), 0);
    idle(BIT * 12);
    chk("no push after reset", int'(bus.rx_valid), 0);
    chk("no errors after reset", (ferr_n - f0) + (oerr_n - o0), 0);
    bus.rx_ready = 1'b1;
    v0 = vcyc;
    send(8'hFF, 1'b1, BIT);
    idle(100);
    chk("FF valid cycles", vcyc - v0, 1);
    chk("FF data", int'(last_data), 8'hFF);
    chk("FF errors", (ferr_n - f0) + (oerr_n - o0), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_cts.md
UART_RX_CTS -- requirements
Module: uart_rx_cts

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 25000000, giving the clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, giving the serial bit rate.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 8 (power of two, at least 4), giving the number of receive buffer entries.
REQ-004 Port clk25, input, 1 bit: the single system clock; all state SHALL be updated only on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset that is synchronous and active-low.
REQ-006 Port uart_rx, input, 1 bit: asynchronous serial line, which idles high.
REQ-007 Port uart_cts, output, 1 bit: active-low clear-to-send (0 = host may transmit).
REQ-008 Port rx_data, output, 8 bits: the byte at the FIFO head.
REQ-009 Port rx_valid, output, 1 bit: high whenever the FIFO is not empty.
REQ-010 Port rx_ready, input, 1 bit: consumer accept.
REQ-011 Port framing_err, output, 1 bit: one-cycle pulse raised on a bad stop bit.
REQ-012 Port overrun_err, output, 1 bit: one-cycle pulse raised when a byte is dropped because the FIFO is full.

Function
REQ-013 uart_rx SHALL pass through a 2-flop synchronizer; all line decisions SHALL use the synchronized value.
REQ-014 BIT_TICKS SHALL equal CLK_FREQ/BAUD (integer division; 217 at the defaults), and HALF_TICKS SHALL equal BIT_TICKS/2 (108).
REQ-015 The receiver SHALL be an FSM with states IDLE, START, DATA and STOP, plus one tick counter and one 3-bit bit index.
REQ-016 IDLE -> START SHALL occur on the first synchronized low, with the tick counter cleared.
REQ-017 In START, after HALF_TICKS cycles, the line SHALL be sampled: low -> DATA with the counter cleared; high -> IDLE (glitch rejected, no error).
REQ-018 In DATA, the line SHALL be sampled every BIT_TICKS cycles into the shift register, LSB first; after bit index 7 the FSM SHALL go to STOP.
REQ-019 In STOP, the line SHALL be sampled after BIT_TICKS cycles: high -> byte push request; low -> framing_err pulse for one cycle and byte discarded; either way the FSM SHALL then go to IDLE.
REQ-020 After a framing error, the FSM SHALL return to IDLE and SHALL NOT restart while the line stays low; a new START SHALL require a high-to-low transition.
REQ-021 The FIFO SHALL be circular with FIFO_DEPTH entries, wrapping read and write pointers, and a count of width log2(FIFO_DEPTH)+1.
REQ-022 A push SHALL be accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
REQ-023 Otherwise the push SHALL be dropped, overrun_err SHALL pulse for one cycle, and the FIFO contents SHALL be unchanged.
REQ-024 A pop SHALL occur when rx_valid and rx_ready are both high; rx_ready while empty SHALL have no effect.
REQ-025 When push and pop occur in the same cycle, count SHALL be unchanged and both pointers SHALL advance.
REQ-026 rx_data SHALL show the head entry combinationally from the FIFO memory; rx_valid SHALL go high on the cycle after the accepted push edge.
REQ-027 Latency SHALL be: stop-bit sample edge -> rx_valid high, 1 cycle (empty FIFO).
REQ-028 uart_cts SHALL be registered; it SHALL go 1 when count >= FIFO_DEPTH-2 and return to 0 when count <= FIFO_DEPTH/2 (hysteresis); between those levels it SHALL hold its value.
REQ-029 rx_data SHALL be stable while rx_valid is high and rx_ready is low.

Reset
REQ-030 While rst_n = 0 at a clock edge, the FSM SHALL go to IDLE, and the counters, pointers, count and shift register SHALL clear.
REQ-031 While rst_n = 0 at a clock edge, rx_valid, framing_err and overrun_err SHALL be 0, rx_data SHALL be 8'h00, and uart_cts SHALL be 1.
REQ-032 The synchronizer flops SHALL reset to 1.
REQ-033 On the first edge with rst_n = 1 and count = 0, uart_cts SHALL go to 0.
REQ-034 Reset mid-frame SHALL abandon the frame without any push or error pulse; buffered bytes SHALL be lost.

Verification
REQ-035 Byte 8'hA5 sent at 217 cycles/bit with rx_ready = 1 -> rx_valid high for exactly 1 cycle with rx_data = 8'hA5; no error pulses.
REQ-036 Low glitch of 50 cycles on an idle line -> FSM back in IDLE; no push and no error.
REQ-037 Byte 8'h3C with the stop bit held low -> framing_err pulses for 1 cycle; rx_valid stays 0; the next valid frame, 8'h55, is received correctly.
REQ-038 With rx_ready = 0, send 9 bytes 8'h01..8'h09 -> uart_cts = 1 once count reaches 6; the 9th byte gives an overrun_err pulse; draining yields 8'h01..8'h08 in order; uart_cts returns to 0 at count 4.
REQ-039 FIFO full with rx_ready = 1 in the same cycle as the stop-bit push -> no overrun; count stays 8; the pointers wrap correctly.
REQ-040 rst_n low at bit index 4 of a frame -> all outputs at reset values; after release, the next frame 8'hFF is received cleanly.
